// File: rtl/rr_arb_pkg.sv
// Shared constants for the four-way round-robin arbiter: requester count,
// hold counter width and the controller state encoding.
package rr_arb_pkg;

    localparam int NREQ   = 4;
    localparam int HOLD_W = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

endpackage

// File: rtl/rr_arbiter4_gnt_decode.sv
// Turns the registered owner index into one-hot grant lines; all lines low
// when no grant is valid.
module gnt_decode
    import rr_arb_pkg::*;
(
    input  logic [1:0]      idx,
    input  logic            en,
    output logic [NREQ-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for four requesters with a hold limit under contention
// and a one-cycle turnaround gap after every grant.
module rr_arbiter4
    import rr_arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      gnt_idx,
    output logic            gnt_valid,
    output logic            forced
);

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(HOLD_MAX);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_MAX - 1);

    logic [1:0]        state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        gnt_idx_q, gnt_idx_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic              forced_q, forced_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]        winner;
    logic              others_waiting;

    // Scan downwards so the requester closest to ptr overwrites the others.
    function automatic logic [1:0] rr_pick(input logic [1:0] ptr,
                                           input logic [NREQ-1:0] r);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (r[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    assign winner         = rr_pick(ptr_q, req);
    assign others_waiting = |(req & ~(NREQ'(1) << gnt_idx_q));

    // ptr moves past the owner on release, so the gap cycle already
    // arbitrates with the owner at the lowest priority.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        forced_d    = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = GRANT;
                    gnt_idx_d   = winner;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                end
            end
            GRANT: begin
                if (hold_cnt_q != HOLD_LIMIT) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
                if (!req[gnt_idx_q]) begin
                    state_d     = GAP;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_idx_q + 2'd1;
                end else if ((hold_cnt_q == HOLD_LAST) && others_waiting) begin
                    state_d     = GAP;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_idx_q + 2'd1;
                    forced_d    = 1'b1;
                end
            end
            GAP: begin
                if (|req) begin
                    state_d     = GRANT;
                    gnt_idx_d   = winner;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            forced_q    <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            forced_q    <= forced_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    gnt_decode u_gnt_decode (
        .idx    (gnt_idx_q),
        .en     (gnt_valid_q),
        .onehot (gnt)
    );

    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign forced    = forced_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: one instance at HOLD_MAX=16 and a second
// at HOLD_MAX=1, checked against hand-computed grant sequences.
module tb_rr_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] req_b;
    logic [3:0] gnt_a, gnt_b;
    logic [1:0] idx_a, idx_b;
    logic       valid_a, valid_b;
    logic       forced_a, forced_b;
    logic [7:0] obs_a, obs_b;

    int checks;
    int errors;

    rr_arbiter4 #(.HOLD_MAX(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt_a),
        .gnt_idx   (idx_a),
        .gnt_valid (valid_a),
        .forced    (forced_a)
    );

    rr_arbiter4 #(.HOLD_MAX(1)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .req       (req_b),
        .gnt       (gnt_b),
        .gnt_idx   (idx_b),
        .gnt_valid (valid_b),
        .forced    (forced_b)
    );

    assign obs_a = {gnt_a, idx_a, valid_a, forced_a};
    assign obs_b = {gnt_b, idx_b, valid_b, forced_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // The index is compared only where it is defined (valid grant or reset).
    task automatic checkOutput(input string tag, input logic [7:0] obs,
                               input logic [3:0] exp_gnt, input logic [1:0] exp_idx,
                               input logic exp_valid, input logic exp_forced,
                               input logic chk_idx);
        logic [7:0] o;
        logic [7:0] e;
        o = obs;
        e = {exp_gnt, exp_idx, exp_valid, exp_forced};
        if (!chk_idx) begin
            o[3:2] = 2'b00;
            e[3:2] = 2'b00;
        end
        checkValue(tag, {24'd0, o}, {24'd0, e});
    endtask

    initial begin
        logic [1:0] owner;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        req    = 4'b0000;
        req_b  = 4'b0000;

        applyStimulus(4'b0000);
        applyStimulus(4'b0000);
        rst = 1'b0;
        checkOutput("reset_state", obs_a, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);

        applyStimulus(4'b0100);
        checkOutput("single_req2", obs_a, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'b0100);
        checkOutput("single_req2_hold", obs_a, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'b0000);
        checkOutput("release2_gap", obs_a, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0000);
        checkOutput("release2_idle", obs_a, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1001);
        checkOutput("ptr3_picks3", obs_a, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'b0001);
        checkOutput("rel3_gap", obs_a, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0001);
        checkOutput("after3_grant0", obs_a, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'b0000);
        applyStimulus(4'b0000);
        checkOutput("rel0_idle", obs_a, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1001);
        checkOutput("ptr1_picks3", obs_a, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'b0001);
        checkOutput("ptr1_gap", obs_a, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0001);
        checkOutput("ptr1_then0", obs_a, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'b0000);
        applyStimulus(4'b0000);

        rst = 1'b1;
        applyStimulus(4'b0000);
        rst = 1'b0;
        checkOutput("reset2_state", obs_a, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
        for (int g = 0; g < 5; g++) begin
            owner = 2'(g);
            for (int c = 0; c < 16; c++) begin
                applyStimulus(4'b1111);
                checkOutput($sformatf("all4_grant%0d_c%0d", g, c), obs_a,
                            4'b0001 << owner, owner, 1'b1, 1'b0, 1'b1);
            end
            applyStimulus(4'b1111);
            checkOutput($sformatf("all4_forced_gap%0d", g), obs_a,
                        4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
        end

        rst = 1'b1;
        applyStimulus(4'b0000);
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            applyStimulus(4'b0001);
            checkOutput($sformatf("solo0_c%0d", c), obs_a,
                        4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
        end
        checkValue("hold_cnt_saturated", {24'd0, dut.hold_cnt_q}, 32'd16);
        applyStimulus(4'b0000);
        checkOutput("solo0_release_gap", obs_a, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0000);

        rst = 1'b1;
        applyStimulus(4'b0000);
        rst = 1'b0;
        applyStimulus(4'b0100);
        checkOutput("reraise_grant2", obs_a, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'b0101);
        checkOutput("nonowner_join0", obs_a, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'b1101);
        checkOutput("nonowner_join3", obs_a, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'b0001);
        checkOutput("owner2_drop_gap", obs_a, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0101);
        checkOutput("reraise_loses_to0", obs_a, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'b0101);
        checkOutput("owner0_holds", obs_a, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'b0100);
        checkOutput("owner0_drop_gap", obs_a, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0100);
        checkOutput("req2_served", obs_a, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'b0000);
        applyStimulus(4'b0000);

        applyStimulus(4'b0010);
        checkOutput("pre_reset_grant1", obs_a, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        applyStimulus(4'b0010);
        checkOutput("midgrant_reset", obs_a, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        applyStimulus(4'b0010);
        checkOutput("post_reset_grant1", obs_a, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'b0000);

        req_b = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            owner = 2'(g);
            applyStimulus(4'b0000);
            checkOutput($sformatf("hold1_grant%0d", g), obs_b,
                        4'b0001 << owner, owner, 1'b1, 1'b0, 1'b1);
            applyStimulus(4'b0000);
            checkOutput($sformatf("hold1_gap%0d", g), obs_b,
                        4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
        end
        req_b = 4'b0000;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Round-robin arbiter sharing one resource among four requesters. It registers a 2-bit grant index and turns it into four one-hot grant lines through a small 2-to-4 decode stage. A grant is held until the owner drops its request, or until a programmable hold limit expires while another requester is waiting. Each grant is followed by a one-cycle turnaround gap. The block sits between the requester front-ends and the shared resource's select/enable inputs.

## Interface
- HOLD_MAX, 16: maximum consecutive grant cycles before a forced release when others are waiting; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines; bit i = requester i. Held high for as long as access is wanted.
- gnt  output  4  one-hot grant; all-zero when nobody owns the resource.
- gnt_idx  output  2  index of the current owner; meaningful only when gnt_valid=1.
- gnt_valid  output  1  high while any gnt bit is high.
- forced  output  1  one-cycle pulse on the gap cycle that follows a hold-limit release.

## Operation
- State machine states: IDLE, GRANT, GAP. All outputs are registered.
- Priority pointer ptr (2 bits). Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4. The first asserted req in that order wins.
- IDLE
  - If req==0, stay in IDLE.
  - Otherwise, arbitrate and go to GRANT: load gnt_idx with the winner, set gnt_valid=1, clear hold_cnt to 0.
- GRANT: hold_cnt (8 bits) increments each cycle and saturates at HOLD_MAX. Conditions are checked in priority order:
  1. req[gnt_idx]==0: go to GAP; normal release.
  2. hold_cnt==HOLD_MAX-1 and some other req bit is high: go to GAP; forced release, forced=1 on the GAP cycle.
  3. Otherwise stay in GRANT. At the limit with no other requester, the grant continues indefinitely.
- GAP
  - Outputs: gnt=0 and gnt_valid=0.
  - ptr becomes gnt_idx+1 mod 4.
  - Arbitration runs this cycle using the updated ptr. If any req is high, go straight to GRANT; otherwise go to IDLE.
- gnt equals the decode of gnt_idx when gnt_valid=1, and 4'b0000 otherwise.
- Boundary conditions:
  - All four requesting: grants cycle 0,1,2,3,0… (starting from ptr), with exactly one gap cycle between grants.
  - Owner drops and re-raises req during the gap: it competes at the lowest priority, since ptr has already moved past it.
  - req changes on non-owner bits during GRANT: no effect on the current grant.
  - HOLD_MAX=1: with contention, each grant lasts exactly 1 cycle.

## Timing
- Reset (rst sampled high at an edge): after that edge, state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, forced=0, ptr=0, hold_cnt=0.
  - Reset mid-grant drops gnt on that same edge, with no gap semantics.
  - Reset takes priority over all other transitions.
- Request to grant: req sampled high at edge N gives gnt high after edge N, i.e. 1-cycle latency from IDLE.
- Release to next grant: owner's req sampled low at edge N gives gnt=0 after N (the gap cycle) and the new gnt after N+1.
- Grant duration: with contention and the owner holding req, a grant lasts exactly HOLD_MAX cycles.
- No combinational path from req to gnt.

## Structure
- Shared package rr_arb_pkg holds:
  - state encoding constants IDLE=2'd0, GRANT=2'd1, GAP=2'd2;
  - the requester count NREQ=4;
  - the hold counter width 8.
- Sub-module gnt_decode: 2-bit index plus enable in, 4-bit one-hot out, purely combinational, driven by the registered gnt_idx and gnt_valid. It is instantiated once.
- The round-robin search is a combinational function inside rr_arbiter4.

## Test plan
- Reset, then req=4'b0100 held: gnt=4'b0100 one cycle later and gnt_idx=2. Drop req: gnt=0 the next cycle, state returns to IDLE, ptr=3.
- From reset, req=4'b1111 held with HOLD_MAX=16: grants 0,1,2,3,0 in order, each 16 cycles long, each followed by exactly one gnt=0 cycle with forced=1.
- Single requester req=4'b0001 held for 100 cycles: gnt=4'b0001 continuously, never forced, hold_cnt saturates at 16.
- ptr=1 and req=4'b1001: requester 3 is granted before requester 0. After requester 3 releases, requester 0 is granted following one gap cycle.
- Owner 2 releases and re-raises req during the gap while req[0]=1: requester 0 wins. Requester 2 is served after requester 0 releases.
- rst asserted mid-grant with req=4'b0010: gnt=0, gnt_valid=0 and gnt_idx=0 after the reset edge. After rst deasserts, requester 1 is re-granted one cycle later.
